// File: rtl/handshake_resync_arbiter.sv
// Send-side controller for a four-phase valid/ack CDC channel: round-robin
// arbitration among NUM_REQ requesters, holding the winner's word stable for a full handshake.
module handshake_resync_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic                          o_sync_valid,
  output logic [DATA_WIDTH-1:0]         o_sync_data,
  input  logic                          i_sync_ack,
  output logic                          o_busy,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_idx,
  output logic                          o_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] TO   = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RELEASE} state_t;

  state_t                r_state;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_grant;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_timeout;
  logic [CW-1:0]         r_cnt;

  logic [IW-1:0]         w_win;
  logic [IW-1:0]         w_k;
  logic                  w_any;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_word;

  // Walk from pointer+1 around the ring; the first valid requester wins.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_k   = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = (w_k == LAST) ? '0 : w_k + IW'(1);
      if (i_req_valid[w_k] && !w_any) begin
        w_win = w_k;
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (IW'(i) == w_win) w_word = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // A stale ack left over from an interrupted handshake blocks new grants.
  assign w_xfer      = (r_state == S_IDLE) && !i_sync_ack && w_any && !i_rst;
  assign o_req_ready = w_xfer ? (NUM_REQ'(1) << w_win) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= LAST;
      r_grant   <= LAST;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_xfer) begin
            r_state <= S_SEND;
            r_data  <= w_word;
            r_grant <= w_win;
            r_ptr   <= w_win;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_SEND: begin
          if (i_sync_ack) begin
            r_state <= S_RELEASE;
            r_valid <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt != TO) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == TO - CW'(1)) r_timeout <= 1'b1;
          end
        end
        S_RELEASE: begin
          if (!i_sync_ack) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt != TO) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == TO - CW'(1)) r_timeout <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_sync_valid = r_valid;
  assign o_sync_data  = r_data;
  assign o_busy       = r_busy;
  assign o_grant_idx  = r_grant;
  assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_handshake_resync_arbiter.sv
// Directed bench for handshake_resync_arbiter: NUM_REQ=3, DATA_WIDTH=8, TIMEOUT_CYCLES=16.
module tb_handshake_resync_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rv;
  logic [2:0]  rdy;
  logic [23:0] rd;
  logic        sv;
  logic [7:0]  sd;
  logic        ack;
  logic        busy;
  logic [1:0]  gidx;
  logic        tmo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  handshake_resync_arbiter #(.DATA_WIDTH(8), .NUM_REQ(3), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(rv), .o_req_ready(rdy), .i_req_data(rd),
    .o_sync_valid(sv), .o_sync_data(sd), .i_sync_ack(ack), .o_busy(busy),
    .o_grant_idx(gidx), .o_timeout(tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rv = '0; ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rv = 3'b111; rd = {8'h30, 8'h20, 8'h10}; ack = 1'b0;
    #1;
    checks++; if (rdy !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b exp 000", rdy); end
    tick();
    checks++; if (sv !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", sv); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (gidx !== 2'd2) begin errors++; $display("FAIL reset_grant: got %0d exp 2", gidx); end
    checks++; if (sd !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", sd); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b exp 0", tmo); end
    checks++; if (rdy !== 3'b000) begin errors++; $display("FAIL reset_ready2: got %b exp 000", rdy); end
    rst = 1'b0; rv = '0;
  endtask

  task automatic test_single_word();
    int nv;
    do_reset();
    rv = 3'b010; rd = 24'h00A500;
    #1;
    checks++; if (rdy !== 3'b010) begin errors++; $display("FAIL sw_ready: got %b exp 010", rdy); end
    tick();
    rv = '0;
    nv = 0;
    for (int c = 1; c <= 12; c++) begin
      ack = (c >= 5 && c < 10);
      #1;
      if (sv === 1'b1) nv++;
      checks++; if (sv !== (c <= 5)) begin errors++; $display("FAIL sw_valid c%0d: got %b exp %b", c, sv, c <= 5); end
      checks++; if (busy !== (c <= 10)) begin errors++; $display("FAIL sw_busy c%0d: got %b exp %b", c, busy, c <= 10); end
      checks++; if (sd !== 8'hA5) begin errors++; $display("FAIL sw_data c%0d: got %h exp a5", c, sd); end
      checks++; if (gidx !== 2'd1) begin errors++; $display("FAIL sw_grant c%0d: got %0d exp 1", c, gidx); end
      checks++; if (rdy !== 3'b000) begin errors++; $display("FAIL sw_ready_idle c%0d: got %b exp 000", c, rdy); end
      tick();
    end
    ack = 1'b0;
    checks++; if (nv != 5) begin errors++; $display("FAIL sw_valid_len: got %0d exp 5", nv); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [3] = '{8'h10, 8'h20, 8'h30};
    logic [1:0] prev;
    logic [1:0] w;
    logic [2:0] er;
    do_reset();
    rv = 3'b111; rd = {8'h30, 8'h20, 8'h10};
    prev = 2'd3;
    for (int r = 0; r < 6; r++) begin
      w  = 2'(r % 3);
      er = 3'b001 << w;
      #1;
      checks++; if (rdy !== er) begin errors++; $display("FAIL rr_ready r%0d: got %b exp %b", r, rdy, er); end
      tick();
      checks++; if (sv !== 1'b1) begin errors++; $display("FAIL rr_valid r%0d: got %b exp 1", r, sv); end
      checks++; if (gidx !== w) begin errors++; $display("FAIL rr_grant r%0d: got %0d exp %0d", r, gidx, w); end
      checks++; if (sd !== exp_d[w]) begin errors++; $display("FAIL rr_data r%0d: got %h exp %h", r, sd, exp_d[w]); end
      checks++; if (gidx === prev) begin errors++; $display("FAIL rr_repeat r%0d: got %0d exp not %0d", r, gidx, prev); end
      prev = gidx;
      ack = 1'b1;
      tick();
      checks++; if (sv !== 1'b0) begin errors++; $display("FAIL rr_release r%0d: got %b exp 0", r, sv); end
      ack = 1'b0;
      tick();
    end
    rv = '0;
  endtask

  task automatic test_stale_ack();
    ack = 1'b1; rst = 1'b1; rv = 3'b001; rd = 24'h000077;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (rdy !== 3'b000) begin errors++; $display("FAIL stale_ready c%0d: got %b exp 000", c, rdy); end
      checks++; if (sv !== 1'b0) begin errors++; $display("FAIL stale_valid c%0d: got %b exp 0", c, sv); end
      tick();
    end
    ack = 1'b0;
    #1;
    checks++; if (rdy !== 3'b001) begin errors++; $display("FAIL stale_grant_ready: got %b exp 001", rdy); end
    tick();
    rv = '0;
    checks++; if (sv !== 1'b1) begin errors++; $display("FAIL stale_valid_after: got %b exp 1", sv); end
    checks++; if (sd !== 8'h77) begin errors++; $display("FAIL stale_data: got %h exp 77", sd); end
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    tick();
  endtask

  task automatic test_reset_in_send();
    do_reset();
    rv = 3'b001; rd = 24'h00005A;
    tick();
    checks++; if (sv !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rs_pre: got v=%b b=%b exp v=1 b=1", sv, busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0; rv = '0;
    #1;
    checks++; if (sv !== 1'b0) begin errors++; $display("FAIL rs_valid: got %b exp 0", sv); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rs_busy: got %b exp 0", busy); end
    checks++; if (gidx !== 2'd2) begin errors++; $display("FAIL rs_grant: got %0d exp 2", gidx); end
    checks++; if (sd !== 8'h00) begin errors++; $display("FAIL rs_data: got %h exp 00", sd); end
  endtask

  task automatic test_timeout();
    do_reset();
    rv = 3'b100; rd = 24'h3C0000;
    tick();
    rv = '0;
    for (int c = 1; c <= 25; c++) begin
      ack = (c >= 21 && c < 23);
      #1;
      checks++; if (tmo !== (c >= 17)) begin errors++; $display("FAIL to_flag c%0d: got %b exp %b", c, tmo, c >= 17); end
      checks++; if (sv !== (c <= 21)) begin errors++; $display("FAIL to_valid c%0d: got %b exp %b", c, sv, c <= 21); end
      checks++; if (busy !== (c <= 23)) begin errors++; $display("FAIL to_busy c%0d: got %b exp %b", c, busy, c <= 23); end
      tick();
    end
    ack = 1'b0;
  endtask

  task automatic test_data_stability();
    do_reset();
    rv = 3'b010; rd = 24'h005500;
    tick();
    for (int c = 1; c <= 6; c++) begin
      rd[15:8] = 8'($urandom);
      rv  = (c <= 4) ? 3'b010 : 3'b000;
      ack = (c >= 3 && c < 5);
      #1;
      checks++; if (sd !== 8'h55) begin errors++; $display("FAIL ds_data c%0d: got %h exp 55", c, sd); end
      checks++; if (rdy !== 3'b000) begin errors++; $display("FAIL ds_ready c%0d: got %b exp 000", c, rdy); end
      tick();
    end
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rv = '0; rd = '0; ack = 1'b0;
    test_reset();
    test_single_word();
    test_round_robin();
    test_stale_ack();
    test_reset_in_send();
    test_data_stability();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
